// File: rtl/bram_bank_arbiter.sv
// Two-port round-robin arbiter in front of one single-port BRAM bank, with a zero-fill clear after reset.
// Optional macro BRAM_ARB_GNT_CNT_EN adds saturating per-port accepted-request counters.
module bram_bank_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 11,
    parameter int DEPTH      = 2048
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rq0_req,
    input  logic                  rq0_we,
    input  logic [ADDR_WIDTH-1:0] rq0_addr,
    input  logic [DATA_WIDTH-1:0] rq0_wdata,
    output logic                  rq0_gnt,
    output logic                  rq0_rvalid,
    output logic [DATA_WIDTH-1:0] rq0_rdata,
    input  logic                  rq1_req,
    input  logic                  rq1_we,
    input  logic [ADDR_WIDTH-1:0] rq1_addr,
    input  logic [DATA_WIDTH-1:0] rq1_wdata,
    output logic                  rq1_gnt,
    output logic                  rq1_rvalid,
    output logic [DATA_WIDTH-1:0] rq1_rdata,
    output logic                  bank_en,
    output logic                  bank_we,
    output logic [ADDR_WIDTH-1:0] bank_addr,
    output logic [DATA_WIDTH-1:0] bank_din,
    input  logic [DATA_WIDTH-1:0] bank_dout,
`ifdef BRAM_ARB_GNT_CNT_EN
    output logic [15:0]           gnt_cnt0,
    output logic [15:0]           gnt_cnt1,
`endif
    output logic                  init_done
);

    typedef enum logic {CLEAR, ARB} state_t;

    state_t                  state_p0;
    logic [ADDR_WIDTH-1:0]   clr_cnt_p0;
    logic                    last_p0;
    logic                    rd_vld_p0;
    logic                    rd_own_p0;
    logic                    init_done_p0;
    logic                    arb;
    logic                    clearing;

    // Clear writes are gated by rst so the bank stays idle while reset is held.
    assign arb      = (state_p0 == ARB);
    assign clearing = (state_p0 == CLEAR) && !rst;

    assign rq0_gnt = arb && rq0_req && (!rq1_req || last_p0);
    assign rq1_gnt = arb && rq1_req && (!rq0_req || !last_p0);

    assign bank_en   = clearing || rq0_gnt || rq1_gnt;
    assign bank_we   = clearing || (rq0_gnt && rq0_we) || (rq1_gnt && rq1_we);
    assign bank_addr = (state_p0 == CLEAR) ? clr_cnt_p0 : (rq1_gnt ? rq1_addr : rq0_addr);
    assign bank_din  = (state_p0 == CLEAR) ? '0 : (rq1_gnt ? rq1_wdata : rq0_wdata);

    assign rq0_rvalid = rd_vld_p0 && !rd_own_p0;
    assign rq1_rvalid = rd_vld_p0 && rd_own_p0;
    assign rq0_rdata  = rq0_rvalid ? bank_dout : '0;
    assign rq1_rdata  = rq1_rvalid ? bank_dout : '0;
    assign init_done  = init_done_p0;

    // Stage p0: FSM, round-robin pointer and read-owner tag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p0     <= CLEAR;
            clr_cnt_p0   <= '0;
            last_p0      <= 1'b1;
            rd_vld_p0    <= 1'b0;
            rd_own_p0    <= 1'b0;
            init_done_p0 <= 1'b0;
        end else begin
            case (state_p0)
                CLEAR: begin
                    clr_cnt_p0 <= clr_cnt_p0 + 1'b1;
                    if (clr_cnt_p0 == ADDR_WIDTH'(DEPTH - 1)) begin
                        state_p0     <= ARB;
                        init_done_p0 <= 1'b1;
                    end
                end
                default: begin
                    if (rq0_gnt)
                        last_p0 <= 1'b0;
                    else if (rq1_gnt)
                        last_p0 <= 1'b1;
                end
            endcase
            rd_vld_p0 <= (rq0_gnt && !rq0_we) || (rq1_gnt && !rq1_we);
            rd_own_p0 <= rq1_gnt;
        end
    end

`ifdef BRAM_ARB_GNT_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Stage p0: accepted-request counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else begin
            if (rq0_gnt)
                gnt_cnt0 <= sat_inc(gnt_cnt0);
            if (rq1_gnt)
                gnt_cnt1 <= sat_inc(gnt_cnt1);
        end
    end
`endif

endmodule
